// File: rtl/randomizer_packer.sv
// randomizer_packer: consumes the randomizer's 2-bit symbol stream, optionally
// von Neumann debiases each symbol, packs the accepted bits MSB-first into
// bytes and buffers the bytes in a first-word-fall-through FIFO.
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset (clears packer, FIFO and drop count)
//   i_en     symbol enable; i_r is consumed on edges where i_en=1
//   i_r      2-bit random symbol
//   o_data   head-of-FIFO byte, meaningful while o_valid=1
//   o_valid  FIFO non-empty
//   i_ready  consumer accepts o_data on edges where o_valid & i_ready
//   o_level  number of bytes held in the FIFO
//   o_drop   bytes discarded because the FIFO was full (saturates at 255)
module randomizer_packer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DEBIAS = 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_en,
  input  logic [1:0]                     i_r,
  output logic [7:0]                     o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [$clog2(DEPTH+1)-1:0]     o_level,
  output logic [7:0]                     o_drop
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    sh_q, sh_d, sh_next;
  logic [3:0]    cnt_q, cnt_d, cnt_next;
  logic          take, complete;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    drop_q;
  logic          full, pop, push, drop;

  // Bit acceptance and byte assembly.
  always_comb begin
    take     = 1'b0;
    sh_next  = sh_q;
    cnt_next = cnt_q;
    if (DEBIAS != 0) begin
      // Only 10 and 01 carry a bit; the bit equals i_r[1].
      take     = i_en & (i_r[1] ^ i_r[0]);
      sh_next  = {sh_q[6:0], i_r[1]};
      cnt_next = cnt_q + 4'd1;
    end else begin
      take     = i_en;
      sh_next  = {sh_q[5:0], i_r};
      cnt_next = cnt_q + 4'd2;
    end
    complete = take && (cnt_next == 4'd8);
    sh_d     = take ? sh_next : sh_q;
    cnt_d    = take ? (complete ? 4'd0 : cnt_next) : cnt_q;
  end

  // FIFO control; a full FIFO still accepts when the head leaves on the same edge.
  always_comb begin
    full = (level_q == LW'(DEPTH));
    pop  = (level_q != '0) && i_ready;
    push = complete && (!full || pop);
    drop = complete && full && !pop;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_q    <= 8'h00;
      cnt_q   <= 4'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= sh_next;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign o_data  = mem_q[rptr_q];
  assign o_valid = (level_q != '0);
  assign o_level = level_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_randomizer_packer.sv
module tb_randomizer_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] r = 2'b00;
  logic       rdy = 1'b0;

  logic [7:0] data0, data1, drop0, drop1;
  logic       valid0, valid1;
  logic [2:0] level0, level1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Raw-bit packer.
  randomizer_packer #(.DEPTH(4), .DEBIAS(0)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .i_r     (r),
    .o_data  (data0),
    .o_valid (valid0),
    .i_ready (rdy),
    .o_level (level0),
    .o_drop  (drop0)
  );

  // Debiasing packer.
  randomizer_packer #(.DEPTH(4), .DEBIAS(1)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .i_r     (r),
    .o_data  (data1),
    .o_valid (valid1),
    .i_ready (rdy),
    .o_level (level1),
    .o_drop  (drop1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic sym(input logic [1:0] s);
    en = 1'b1;
    r  = s;
    tick();
    en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    sym(v[7:6]);
    sym(v[5:4]);
    sym(v[3:2]);
    sym(v[1:0]);
  endtask

  logic [7:0] b;

  initial begin
    // Reset state.
    tick();
    do_reset();
    check_eq("rst_valid0", valid0, 0);
    check_eq("rst_data0", data0, 8'h00);
    check_eq("rst_level0", level0, 0);
    check_eq("rst_drop0", drop0, 0);
    check_eq("rst_valid1", valid1, 0);
    check_eq("rst_data1", data1, 8'h00);

    // Raw mode: 11,00,10,01 -> C9, popped the cycle it appears.
    rdy = 1'b1;
    sym(2'b11); sym(2'b00); sym(2'b10);
    check_eq("raw_early_valid", valid0, 0);
    sym(2'b01);
    check_eq("raw_valid", valid0, 1);
    check_eq("raw_data", data0, 8'hC9);
    check_eq("raw_level", level0, 1);
    tick();
    check_eq("raw_valid_fall", valid0, 0);
    check_eq("raw_level_fall", level0, 0);

    // Debias mode: bits 1,0,1,1,0,0,1,0 -> B2 after the 10th symbol.
    do_reset();
    rdy = 1'b0;
    sym(2'b10); sym(2'b00); sym(2'b01); sym(2'b11); sym(2'b10);
    sym(2'b10); sym(2'b01); sym(2'b01); sym(2'b10);
    check_eq("deb_early_valid", valid1, 0);
    sym(2'b01);
    check_eq("deb_valid", valid1, 1);
    check_eq("deb_data", data1, 8'hB2);
    check_eq("deb_level", level1, 1);

    // Overflow: 6 bytes into a 4-deep FIFO, then drain in order.
    do_reset();
    rdy = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      b = 8'(k);
      push_byte(b);
    end
    check_eq("ovf_level", level0, 4);
    check_eq("ovf_drop", drop0, 2);
    rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("drain_level", level0, 32'(5 - k));
      check_eq("drain_data", data0, 32'(k));
      tick();
    end
    check_eq("drain_empty_level", level0, 0);
    check_eq("drain_empty_valid", valid0, 0);
    rdy = 1'b0;

    // Full FIFO: completion and pop on the same edge -> accepted, no drop.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      push_byte(b);
    end
    sym(2'b10); sym(2'b10); sym(2'b01);
    en  = 1'b1;
    r   = 2'b01;
    rdy = 1'b1;
    tick();
    en  = 1'b0;
    rdy = 1'b0;
    check_eq("full_pp_level", level0, 4);
    check_eq("full_pp_drop", drop0, 0);
    check_eq("full_pp_head", data0, 8'h02);
    rdy = 1'b1;
    tick(); tick(); tick();
    check_eq("full_pp_tail", data0, 8'hA5);
    check_eq("full_pp_tail_lvl", level0, 1);
    tick();
    rdy = 1'b0;

    // Enable gating: idle cycles with random symbols contribute nothing.
    do_reset();
    sym(2'b10); sym(2'b11);
    for (int k = 0; k < 5; k++) begin
      en = 1'b0;
      r  = 2'($urandom_range(0, 3));
      tick();
    end
    check_eq("en_idle_valid", valid0, 0);
    sym(2'b00); sym(2'b01);
    check_eq("en_valid", valid0, 1);
    check_eq("en_data", data0, 8'hB1);
    check_eq("en_level", level0, 1);

    // Reset with buffered bytes and a partial byte, then a fresh byte.
    do_reset();
    push_byte(8'h11);
    push_byte(8'h22);
    sym(2'b11); sym(2'b11); sym(2'b11);
    check_eq("pre_rst_level", level0, 2);
    do_reset();
    check_eq("mid_rst_valid", valid0, 0);
    check_eq("mid_rst_level", level0, 0);
    check_eq("mid_rst_drop", drop0, 0);
    check_eq("mid_rst_data", data0, 8'h00);
    sym(2'b01); sym(2'b10); sym(2'b11);
    check_eq("fresh_early_valid", valid0, 0);
    sym(2'b00);
    check_eq("fresh_valid", valid0, 1);
    check_eq("fresh_data", data0, 8'h6C);
    check_eq("fresh_level", level0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/randomizer_packer.md
Name: randomizer_packer

Overview:
- Downstream consumer of the randomizer's 2-bit output stream.
- Optionally applies von Neumann debiasing to each 2-bit symbol.
- Packs accepted bits MSB-first into bytes and buffers the bytes in a small first-word-fall-through FIFO.
- Presents bytes on a valid/ready interface and counts bytes dropped on overflow.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, >= 2.
- DEBIAS, 1, 1 = von Neumann debias each symbol; 0 = accept both raw bits.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_en  input  1  symbol sample enable; high = i_r is consumed this cycle.
- i_r  input  2  random symbol from the randomizer.
- o_data  output  8  head-of-FIFO byte; valid only while o_valid=1.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts o_data when o_valid & i_ready.
- o_level  output  $clog2(DEPTH+1)  bytes currently held in the FIFO.
- o_drop  output  8  bytes dropped due to a full FIFO; saturates at 255.

Behaviour:
- Reset (i_reset=1 at a rising edge) clears the following; all outputs are 0 in the cycle after the reset edge:
  - shift register sh[7:0] and bit count cnt;
  - FIFO pointers, o_level and o_drop;
  - o_valid=0 and o_data=8'h00.
- Reset has priority over all other inputs and discards any partial byte and all buffered bytes.
- Symbol acceptance happens only when i_en=1. When i_en=0, sh and cnt hold; the partial byte is retained and the FIFO still drains.
- DEBIAS=1:
  - 2'b10 yields bit 1; 2'b01 yields bit 0.
  - 2'b00 and 2'b11 yield no bit.
  - At most one bit per cycle: sh <= {sh[6:0], b}, cnt += 1.
- DEBIAS=0:
  - Two bits per cycle: sh <= {sh[5:0], i_r[1], i_r[0]}, cnt += 2.
  - cnt is always even, so a byte completes exactly every 4 enabled symbols.
- Byte completion occurs on the edge where the 8th bit is accepted.
  - The completed byte ({sh[6:0],b} or {sh[5:0],i_r}) is the push candidate.
  - cnt returns to 0 on that same edge.
- Push rule: the completed byte is written if level < DEPTH, or if level == DEPTH and a pop occurs on the same edge.
  - Otherwise the byte is discarded and o_drop increments, saturating at 8'hFF.
  - Completion and the sh/cnt reset happen regardless of drop.
- Pop occurs on an edge with o_valid & i_ready. i_ready while o_valid=0 has no effect.
- Level update on each edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Latency: a byte completing at edge N gives o_valid=1 with that o_data in the cycle after edge N, provided the FIFO was empty.
- Ordering: bytes leave in completion order.
- o_data remains stable while o_valid=1 and i_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- No combinational path exists from i_ready or i_r to any output; all outputs are registered or driven directly from FIFO storage.

Test Plan:
- DEBIAS=0, i_ready=1, i_en=1, symbols 11,00,10,01 -> o_valid=1 one cycle after the 4th symbol edge, o_data=8'hC9; o_valid falls after one cycle.
- DEBIAS=1, symbols 10,00,01,11,10,10,01,01,10,01 -> exactly one byte, o_data=8'hB2; no byte is produced before the 10th symbol.
- DEBIAS=0, DEPTH=4, i_ready=0, 24 symbols -> o_level=4 and o_drop=2. Then hold i_ready=1: bytes 1..4 appear in order and o_level counts 4,3,2,1,0.
- FIFO full, i_ready=1, byte completes on the same edge as a pop -> o_level stays 4 and o_drop is unchanged.
- Toggle i_en: 2 symbols, 5 cycles of i_en=0 with random i_r, then 2 more symbols -> one byte formed only from the 4 enabled symbols.
- Assert i_reset after 3 symbols with 2 bytes buffered -> o_valid=0, o_level=0, o_drop=0. The next 4 symbols alone form a fresh byte.
